// File: rtl/lcd_char_arbiter_if.sv
// -----------------------------------------------------------------------------
// lcd_char_arbiter_if
// Bundle between the text producers / character renderer and the arbiter.
//   master : the arbiter side (receives requests and renderer done, drives the
//            renderer start pulse, latched character fields and per-requester ack)
//   slave  : the environment side (producers and renderer)
// Signals:
//   init_done       LCD init complete, gates new grants
//   req             per-requester level request
//   req_ascii/x/y   packed per-requester character fields (7/9/9 bits each)
//   req_size        per-requester font select (1 = 16x8, 0 = 12x6)
//   show_char_done  one-cycle completion pulse from the renderer
//   ack             one-hot completion pulse to the granted requester
//   show_char_flag  one-cycle start pulse to the renderer
//   ascii_num/start_x/start_y/en_size  latched fields of the granted character
//   grant_id        current or last granted requester
//   busy            arbiter not idle
//   timeout_err     draw aborted, coincident with ack
// -----------------------------------------------------------------------------
interface lcd_char_arbiter_if #(
    parameter int N_REQ = 3
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic                 init_done;
    logic [N_REQ-1:0]     req;
    logic [7*N_REQ-1:0]   req_ascii;
    logic [9*N_REQ-1:0]   req_x;
    logic [9*N_REQ-1:0]   req_y;
    logic [N_REQ-1:0]     req_size;
    logic                 show_char_done;
    logic [N_REQ-1:0]     ack;
    logic                 show_char_flag;
    logic [6:0]           ascii_num;
    logic [8:0]           start_x;
    logic [8:0]           start_y;
    logic                 en_size;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  init_done, req, req_ascii, req_x, req_y, req_size, show_char_done,
        output ack, show_char_flag, ascii_num, start_x, start_y, en_size,
               grant_id, busy, timeout_err
    );

    modport slave (
        output init_done, req, req_ascii, req_x, req_y, req_size, show_char_done,
        input  ack, show_char_flag, ascii_num, start_x, start_y, en_size,
               grant_id, busy, timeout_err
    );
endinterface

// File: rtl/lcd_char_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_char_arbiter
// Round-robin arbiter sharing one LCD character renderer between N_REQ text
// producers. A grant latches the winner's character fields, fires a one-cycle
// start pulse, waits for the renderer's done (or a timeout), then pulses the
// winner's ack (with timeout_err on abort) and advances the round-robin pointer.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   bus        lcd_char_arbiter_if.master (requests, renderer handshake, status)
// Parameters:
//   N_REQ        number of requesters (2..8)
//   TIMEOUT_CYC  cycles allowed in WAIT before the draw is aborted (>= 2)
// -----------------------------------------------------------------------------
module lcd_char_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    lcd_char_arbiter_if.master  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    N_EXT    = (ID_W+1)'(N_REQ);
    localparam logic [N_REQ-1:0] ACK_ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic [6:0]         ascii_reg;
    logic [8:0]         x_reg;
    logic [8:0]         y_reg;
    logic               size_reg;
    logic               flag_reg;
    logic [N_REQ-1:0]   ack_reg;
    logic               busy_reg;
    logic               terr_reg;

    // Per-requester views of the packed field buses.
    logic [6:0] ascii_arr [N_REQ];
    logic [8:0] x_arr     [N_REQ];
    logic [8:0] y_arr     [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign ascii_arr[gi] = bus.req_ascii[7*gi +: 7];
            assign x_arr[gi]     = bus.req_x[9*gi +: 9];
            assign y_arr[gi]     = bus.req_y[9*gi +: 9];
        end
    endgenerate

    // Round-robin pick: first set request at offset 0,1,.. from rr_ptr.
    // The loop runs from the farthest offset down so the nearest hit wins.
    // rr_ptr and the offset are both below N_REQ, so one conditional
    // subtraction is enough for the modulo.
    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W:0]      cand_sum;
    logic [ID_W-1:0]    cand_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand_sum >= N_EXT) begin
                cand_sum = cand_sum - N_EXT;
            end
            cand_idx = cand_sum[ID_W-1:0];
            if (bus.req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            ascii_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            size_reg     <= 1'b0;
            flag_reg     <= 1'b0;
            ack_reg      <= '0;
            busy_reg     <= 1'b0;
            terr_reg     <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for one cycle below.
            flag_reg <= 1'b0;
            ack_reg  <= '0;
            terr_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.init_done && sel_found) begin
                        grant_id_reg <= sel_idx;
                        ascii_reg    <= ascii_arr[sel_idx];
                        x_reg        <= x_arr[sel_idx];
                        y_reg        <= y_arr[sel_idx];
                        size_reg     <= bus.req_size[sel_idx];
                        flag_reg     <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= START;
                    end
                end

                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end

                WAIT: begin
                    // Done takes priority over a timeout landing on the same cycle.
                    if (bus.show_char_done) begin
                        ack_reg   <= ACK_ONE << grant_id_reg;
                        state_reg <= ACK;
                    end else if (cnt_reg == CNT_LAST) begin
                        ack_reg   <= ACK_ONE << grant_id_reg;
                        terr_reg  <= 1'b1;
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ACK: begin
                    rr_ptr_reg <= (grant_id_reg == ID_LAST) ? '0 : grant_id_reg + 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ack            = ack_reg;
    assign bus.show_char_flag = flag_reg;
    assign bus.ascii_num      = ascii_reg;
    assign bus.start_x        = x_reg;
    assign bus.start_y        = y_reg;
    assign bus.en_size        = size_reg;
    assign bus.grant_id       = grant_id_reg;
    assign bus.busy           = busy_reg;
    assign bus.timeout_err    = terr_reg;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_arbiter
// Self-checking bench for lcd_char_arbiter (N_REQ=3). The timeout is set long
// enough for a 20-cycle renderer latency yet short enough to exercise aborts.
// The reference model keeps the round-robin pointer as an integer and picks the
// winner with modulo arithmetic over the request vector.
// -----------------------------------------------------------------------------
module tb_lcd_char_arbiter;
    localparam int N = 3;
    localparam int T = 32;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    always #5 sys_clk = ~sys_clk;

    lcd_char_arbiter_if #(.N_REQ(N)) bus ();

    lcd_char_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (T)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int rr_model    = 0;

    logic [6:0] f_ascii [N];
    logic [8:0] f_x     [N];
    logic [8:0] f_y     [N];
    logic       f_size  [N];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Model: first set request at offsets 0..N-1 from the pointer, modulo N.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic set_fields(input int id, input logic [6:0] a, input logic [8:0] x,
                              input logic [8:0] y, input logic s);
        bus.req_ascii[7*id +: 7] = a;
        bus.req_x[9*id +: 9]     = x;
        bus.req_y[9*id +: 9]     = y;
        bus.req_size[id]         = s;
        f_ascii[id] = a;
        f_x[id]     = x;
        f_y[id]     = y;
        f_size[id]  = s;
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            set_fields(i, 7'($urandom), 9'($urandom), 9'($urandom), 1'($urandom));
        end
    endtask

    task automatic wait_flag(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.show_char_flag === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int budget, output int n, output int flags);
        n = -1;
        flags = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.show_char_flag === 1'b1) flags++;
            if (bus.ack !== '0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        bus.req = '0;
        bus.show_char_done = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        rr_model = 0;
        tick();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        bus.init_done = 1'b1;
        bus.req = 3'b111;
        repeat (3) tick();
        vectors++;
        if ({bus.busy, bus.show_char_flag, bus.ack, bus.timeout_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b flag=%b ack=%b terr=%b, expected all 0",
                     bus.busy, bus.show_char_flag, bus.ack, bus.timeout_err);
        end
        vectors++;
        if ({bus.grant_id, bus.ascii_num, bus.start_x, bus.start_y, bus.en_size} !== 28'b0) begin
            miscompares++;
            $display("FAIL reset_fields: got gid=%0d ascii=%0d x=%0d y=%0d size=%b, expected 0",
                     bus.grant_id, bus.ascii_num, bus.start_x, bus.start_y, bus.en_size);
        end
        bus.req = '0;
        sys_rst_n = 1'b1;
        rr_model = 0;
        tick();
    endtask

    task automatic test_single();
        int n;
        int extra;
        bus.init_done = 1'b1;
        set_fields(1, 7'd82, 9'd72, 9'd16, 1'b0);
        bus.req = 3'b010;
        wait_flag(4, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL single_flag_latency: got %0d cycles, expected 1", n);
        end
        vectors++;
        if ({bus.ascii_num, bus.start_x, bus.start_y, bus.en_size} !== {7'd82, 9'd72, 9'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL single_fields: got ascii=%0d x=%0d y=%0d size=%b, expected 82/72/16/0",
                     bus.ascii_num, bus.start_x, bus.start_y, bus.en_size);
        end
        vectors++;
        if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: got gid=%0d busy=%b, expected 1/1", bus.grant_id, bus.busy);
        end
        extra = 0;
        repeat (19) begin
            tick();
            if (bus.show_char_flag !== 1'b0 || bus.ack !== '0) extra++;
        end
        bus.show_char_done = 1'b1;
        tick();
        bus.show_char_done = 1'b0;
        vectors++;
        if (bus.ack !== 3'b010 || bus.timeout_err !== 1'b0 || extra != 0) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b terr=%b stray=%0d, expected 010/0/0",
                     bus.ack, bus.timeout_err, extra);
        end
        bus.req = '0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.ack !== '0) begin
            miscompares++;
            $display("FAIL single_release: got busy=%b ack=%b, expected 0/000", bus.busy, bus.ack);
        end
        rr_model = 2;
    endtask

    task automatic test_fairness();
        int n;
        int flags;
        int exp;
        apply_reset();
        for (int i = 0; i < N; i++) set_fields(i, 7'(65 + i), 9'(10 * i), 9'(20 * i), 1'(i));
        bus.req = 3'b111;
        for (int r = 0; r < 6; r++) begin
            exp = pick(3'b111, rr_model);
            wait_flag(4, n);
            vectors++;
            if (n < 0 || bus.grant_id !== 2'(exp) || bus.ascii_num !== 7'(65 + exp)) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got gid=%0d ascii=%0d lat=%0d, expected gid=%0d ascii=%0d",
                         r, bus.grant_id, bus.ascii_num, n, exp, 65 + exp);
            end
            repeat ($urandom_range(1, 4)) tick();
            bus.show_char_done = 1'b1;
            wait_ack(2, n, flags);
            bus.show_char_done = 1'b0;
            vectors++;
            if (bus.ack !== (3'b001 << exp) || flags != 0) begin
                miscompares++;
                $display("FAIL fair_ack[%0d]: got ack=%b extra_flags=%0d, expected ack=%b flags=0",
                         r, bus.ack, flags, 3'b001 << exp);
            end
            rr_model = (exp + 1) % N;
            tick();
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        int flags;
        apply_reset();
        bus.req = 3'b010;
        wait_flag(4, n);
        repeat (2) tick();
        bus.show_char_done = 1'b1;
        wait_ack(2, n, flags);
        bus.show_char_done = 1'b0;
        bus.req = '0;
        rr_model = 2;
        tick();
        bus.req = 3'b011;
        wait_flag(4, n);
        vectors++;
        if (n != 1 || bus.grant_id !== 2'(pick(3'b011, rr_model))) begin
            miscompares++;
            $display("FAIL wrap_grant: got gid=%0d lat=%0d, expected gid=%0d lat=1",
                     bus.grant_id, n, pick(3'b011, rr_model));
        end
        repeat (2) tick();
        bus.show_char_done = 1'b1;
        wait_ack(2, n, flags);
        bus.show_char_done = 1'b0;
        bus.req = '0;
        rr_model = 1;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int flags;
        int stray;
        bus.req = 3'b001;
        wait_flag(4, n);
        wait_ack(T + 6, n, flags);
        vectors++;
        if (n != T + 1 || bus.ack !== 3'b001 || bus.timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ack: got delay=%0d ack=%b terr=%b, expected delay=%0d ack=001 terr=1",
                     n, bus.ack, bus.timeout_err, T + 1);
        end
        bus.req = '0;
        tick();
        bus.show_char_done = 1'b1;
        stray = 0;
        repeat (4) begin
            tick();
            bus.show_char_done = 1'b0;
            if (bus.ack !== '0 || bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL timeout_stray_done: got %0d active cycles, expected 0", stray);
        end
        rr_model = 1;
    endtask

    task automatic test_gating();
        int n;
        int flags;
        int bad;
        bus.init_done = 1'b0;
        bus.req = 3'b001;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.show_char_done = (i == 2);
            tick();
            if (bus.show_char_flag !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== '0) bad++;
        end
        bus.show_char_done = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL gate_hold: got %0d active cycles, expected 0", bad);
        end
        bus.init_done = 1'b1;
        tick();
        vectors++;
        if (bus.show_char_flag !== 1'b1 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL gate_release: got flag=%b gid=%0d, expected 1/0", bus.show_char_flag, bus.grant_id);
        end
        // init_done dropping mid-draw must not abort the draw in flight.
        bus.init_done = 1'b0;
        repeat (3) tick();
        bus.show_char_done = 1'b1;
        wait_ack(2, n, flags);
        bus.show_char_done = 1'b0;
        vectors++;
        if (bus.ack !== 3'b001 || bus.timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_middraw_ack: got ack=%b terr=%b, expected 001/0", bus.ack, bus.timeout_err);
        end
        bus.req = 3'b010;
        bad = 0;
        repeat (6) begin
            tick();
            if (bus.show_char_flag !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_after_drop: got flags=%0d busy=%b, expected 0/0", bad, bus.busy);
        end
        bus.req = '0;
        bus.init_done = 1'b1;
        rr_model = 1;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int bad;
        bus.req = 3'b010;
        wait_flag(4, n);
        repeat (3) tick();
        sys_rst_n = 1'b0;
        tick();
        vectors++;
        if ({bus.busy, bus.show_char_flag, bus.ack, bus.timeout_err, bus.grant_id,
             bus.ascii_num, bus.start_x, bus.start_y, bus.en_size} !== 34'b0) begin
            miscompares++;
            $display("FAIL rst_wait: got busy=%b ack=%b gid=%0d ascii=%0d x=%0d y=%0d, expected all 0",
                     bus.busy, bus.ack, bus.grant_id, bus.ascii_num, bus.start_x, bus.start_y);
        end
        bus.req = '0;
        tick();
        sys_rst_n = 1'b1;
        rr_model = 0;
        bus.show_char_done = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            bus.show_char_done = 1'b0;
            if (bus.ack !== '0 || bus.busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rst_no_ack: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_random();
        int n;
        int flags;
        int exp;
        int bad;
        logic [N-1:0] rq;
        logic [25:0]  exp_fields;
        logic         to;
        for (int r = 0; r < 40; r++) begin
            randomize_fields();
            rq = N'($urandom_range(0, 7));
            bus.req = rq;
            if (rq == '0) begin
                bad = 0;
                repeat (3) begin
                    tick();
                    if (bus.busy !== 1'b0 || bus.show_char_flag !== 1'b0) bad++;
                end
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL rnd_idle[%0d]: got %0d active cycles, expected 0", r, bad);
                end
                continue;
            end
            exp = pick(rq, rr_model);
            exp_fields = {f_ascii[exp], f_x[exp], f_y[exp], f_size[exp]};
            wait_flag(4, n);
            vectors++;
            if (n != 1 || bus.grant_id !== 2'(exp) ||
                {bus.ascii_num, bus.start_x, bus.start_y, bus.en_size} !== exp_fields) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: req=%b got gid=%0d fields=%h lat=%0d, expected gid=%0d fields=%h",
                         r, rq, bus.grant_id, {bus.ascii_num, bus.start_x, bus.start_y, bus.en_size},
                         n, exp, exp_fields);
            end
            if (n < 0) begin
                apply_reset();
                continue;
            end
            randomize_fields();
            to = ($urandom_range(0, 7) == 0);
            if (!to) begin
                repeat ($urandom_range(1, 6)) tick();
                bus.show_char_done = 1'b1;
                wait_ack(2, n, flags);
                bus.show_char_done = 1'b0;
            end else begin
                wait_ack(T + 6, n, flags);
            end
            vectors++;
            if (bus.ack !== (3'b001 << exp) || bus.timeout_err !== to || flags != 0 ||
                (to && n != T + 1)) begin
                miscompares++;
                $display("FAIL rnd_ack[%0d]: got ack=%b terr=%b delay=%0d flags=%0d, expected ack=%b terr=%b",
                         r, bus.ack, bus.timeout_err, n, flags, 3'b001 << exp, to);
            end
            vectors++;
            if ({bus.ascii_num, bus.start_x, bus.start_y, bus.en_size} !== exp_fields) begin
                miscompares++;
                $display("FAIL rnd_hold[%0d]: got fields=%h, expected %h", r,
                         {bus.ascii_num, bus.start_x, bus.start_y, bus.en_size}, exp_fields);
            end
            bus.req = '0;
            tick();
            vectors++;
            if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.grant_id !== 2'(exp)) begin
                miscompares++;
                $display("FAIL rnd_release[%0d]: got busy=%b ack=%b gid=%0d, expected 0/000/%0d",
                         r, bus.busy, bus.ack, bus.grant_id, exp);
            end
            rr_model = (exp + 1) % N;
        end
        bus.req = '0;
    endtask

    initial begin
        sys_rst_n          = 1'b0;
        bus.init_done      = 1'b0;
        bus.req            = '0;
        bus.show_char_done = 1'b0;
        bus.req_ascii      = '0;
        bus.req_x          = '0;
        bus.req_y          = '0;
        bus.req_size       = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_gating();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
